// File: rtl/change_event_pkg.sv
// Shared types and defaults for the change-event arbiter.
package change_event_pkg;

  // Kind of a detected transition on an observed signal.
  typedef enum logic {
    EV_FELL = 1'b0,
    EV_ROSE = 1'b1
  } ev_kind_t;

  // Widest channel index needed for the largest supported N (16).
  localparam int CHAN_W = 4;

  // One event as seen by a consumer.
  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    ev_kind_t          kind;
  } ev_t;

  // Default width of the saturating drop counter.
  localparam int DROP_W_DEFAULT = 8;

endpackage

// File: rtl/change_event_arbiter_rr_pick.sv
// Round-robin picker: lowest requesting index at or above rr, wrapping.
module rr_pick
  import change_event_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Scan from the farthest candidate toward rr so the nearest requester wins.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop; otherwise the
    // no-request path would leave them unassigned and infer latches.
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(rr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx[IW-1:0]]) begin
        gnt_idx = idx[IW-1:0];
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_event_arbiter.sv
// Edge detector with sticky per-channel event flags, handed out one at a
// time through a round-robin arbiter on a valid/ready port.
module change_event_arbiter
  import change_event_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int DROP_W = DROP_W_DEFAULT,
  localparam int IW     = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      sig,
  input  logic [N-1:0]      rose_en,
  input  logic [N-1:0]      fell_en,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [IW-1:0]     ev_chan,
  output logic              ev_kind,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              drop_pulse
);

  // Registered state.
  logic [N-1:0]  prev;
  logic          primed;
  logic [N-1:0]  pend_r;
  logic [N-1:0]  pend_f;
  logic [N-1:0]  first;     // 1 = rise arrived first, 0 = fall first
  logic [IW-1:0] rr;

  // Next-state terms.
  logic          hs;
  logic          hold;
  logic [N-1:0]  clr_r, clr_f;
  logic [N-1:0]  det_r, det_f;
  logic [N-1:0]  kept_r, kept_f;
  logic [N-1:0]  pend_r_n, pend_f_n;
  logic [N-1:0]  first_n;
  logic [N-1:0]  req;
  logic [IW-1:0] rr_n;
  logic [IW-1:0] gnt_idx;
  logic          any;
  logic          drop_any;
  ev_kind_t      pick_kind;

  // Detection, flag update, ordering and pointer advance for this edge.
  always_comb begin
    hs   = ev_valid && ev_ready;
    hold = ev_valid && !ev_ready;

    clr_r = '0;
    clr_f = '0;
    if (hs) begin
      if (ev_kind_t'(ev_kind) == EV_ROSE) clr_r[ev_chan] = 1'b1;
      else                                clr_f[ev_chan] = 1'b1;
    end

    // Nothing is detected until prev holds a real sample.
    det_r = primed ? (~prev &  sig & rose_en) : '0;
    det_f = primed ? ( prev & ~sig & fell_en) : '0;

    // A flag that survives this edge and sees a new event loses that event.
    kept_r   = pend_r & ~clr_r;
    kept_f   = pend_f & ~clr_f;
    drop_any = |((det_r & kept_r) | (det_f & kept_f));
    pend_r_n = kept_r | det_r;
    pend_f_n = kept_f | det_f;

    // The kind that survived from before is older than one set on this edge.
    for (int i = 0; i < N; i++) begin
      first_n[i] = first[i];
      if (pend_r_n[i] && pend_f_n[i]) begin
        if (!(kept_r[i] && kept_f[i])) first_n[i] = kept_r[i];
      end else if (pend_r_n[i]) begin
        first_n[i] = 1'b1;
      end else if (pend_f_n[i]) begin
        first_n[i] = 1'b0;
      end
    end

    rr_n = rr;
    if (hs) rr_n = (ev_chan == IW'(N - 1)) ? '0 : ev_chan + 1'b1;

    req = pend_r_n | pend_f_n;
  end

  rr_pick #(.N(N)) u_rr_pick (
    .req     (req),
    .rr      (rr_n),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Kind offered for the winning channel: the older one when both pend.
  always_comb begin
    if (pend_r_n[gnt_idx] && pend_f_n[gnt_idx])
      pick_kind = first_n[gnt_idx] ? EV_ROSE : EV_FELL;
    else if (pend_r_n[gnt_idx])
      pick_kind = EV_ROSE;
    else
      pick_kind = EV_FELL;
  end

  // Past-value sampling, pending flags, order bits and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      prev   <= '0;
      primed <= 1'b0;
      pend_r <= '0;
      pend_f <= '0;
      first  <= '0;
      rr     <= '0;
    end else begin
      prev   <= sig;
      primed <= 1'b1;
      pend_r <= pend_r_n;
      pend_f <= pend_f_n;
      first  <= first_n;
      rr     <= rr_n;
    end
  end

  // Lost-event strobe and saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop_any;
      if (drop_any && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Offer register: held while stalled, otherwise reloaded from the arbiter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_chan  <= '0;
      ev_kind  <= 1'b0;
    end else if (!hold) begin
      ev_valid <= any;
      ev_chan  <= gnt_idx;
      ev_kind  <= pick_kind;
    end
  end

endmodule

// File: tb/tb_change_event_arbiter.sv
// Self-checking bench: queue-based reference model plus directed scenarios
// and randomized traffic.
module tb_change_event_arbiter;
  import change_event_pkg::*;

  localparam int N      = 4;
  localparam int DROP_W = 8;
  localparam int IW     = $clog2(N);
  localparam int SAT    = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      sig;
  logic [N-1:0]      rose_en;
  logic [N-1:0]      fell_en;
  logic              ev_valid;
  logic              ev_ready;
  logic [IW-1:0]     ev_chan;
  logic              ev_kind;
  logic [DROP_W-1:0] drop_cnt;
  logic              drop_pulse;

  always #5 clk = ~clk;

  change_event_arbiter #(.N(N), .DROP_W(DROP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig        (sig),
    .rose_en    (rose_en),
    .fell_en    (fell_en),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_chan    (ev_chan),
    .ev_kind    (ev_kind),
    .drop_cnt   (drop_cnt),
    .drop_pulse (drop_pulse)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: each channel keeps its pending events in arrival order
  // (at most one of each kind); the offer is the head of the chosen channel.
  bit [N-1:0] m_prev;
  bit         m_primed;
  int         qlen [N];
  ev_kind_t   qk   [N][2];
  int         m_rr;
  bit         m_valid;
  ev_t        m_offer;
  int         m_drop_cnt;
  bit         m_drop_pulse;

  task automatic model_reset();
    m_prev = '0; m_primed = 0; m_rr = 0; m_valid = 0;
    m_offer = '0; m_drop_cnt = 0; m_drop_pulse = 0;
    for (int c = 0; c < N; c++) qlen[c] = 0;
  endtask

  task automatic add_event(input int c, input ev_kind_t k, inout bit dropped);
    bit present = 0;
    for (int j = 0; j < qlen[c]; j++) if (qk[c][j] == k) present = 1;
    if (present) dropped = 1;
    else begin
      qk[c][qlen[c]] = k;
      qlen[c]++;
    end
  endtask

  task automatic model_edge();
    bit hold, hs, dropped;
    int c;
    if (rst) begin
      model_reset();
      return;
    end
    hold = m_valid && !ev_ready;
    hs   = m_valid && ev_ready;
    if (hs) begin
      c = int'(m_offer.chan);
      if (qlen[c] == 2 && qk[c][0] == m_offer.kind) qk[c][0] = qk[c][1];
      qlen[c]--;
      m_rr = (c + 1) % N;
    end
    dropped = 0;
    if (m_primed) begin
      for (int i = 0; i < N; i++) begin
        if (!m_prev[i] && sig[i] && rose_en[i]) add_event(i, EV_ROSE, dropped);
        if (m_prev[i] && !sig[i] && fell_en[i]) add_event(i, EV_FELL, dropped);
      end
    end
    m_prev   = sig;
    m_primed = 1;
    m_drop_pulse = dropped;
    if (dropped && m_drop_cnt < SAT) m_drop_cnt++;
    if (!hold) begin
      m_valid = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (qlen[c] > 0) begin
          m_valid      = 1;
          m_offer.chan = CHAN_W'(c);
          m_offer.kind = qk[c][0];
          break;
        end
      end
    end
  endtask

  task automatic compare(input string tag);
    check({tag, ".valid"}, ev_valid, m_valid);
    if (m_valid) begin
      check({tag, ".chan"}, ev_chan, m_offer.chan);
      check({tag, ".kind"}, ev_kind, m_offer.kind);
    end
    check({tag, ".drop_cnt"}, drop_cnt, m_drop_cnt);
    check({tag, ".drop_pulse"}, drop_pulse, m_drop_pulse);
  endtask

  // Drive inputs, let one edge happen, then compare away from the edge.
  task automatic step(input string tag, input logic [N-1:0] s, input logic r, input logic rs);
    sig = s; ev_ready = r; rst = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare(tag);
  endtask

  initial begin
    logic [N-1:0] s;
    rose_en = '1; fell_en = '1;
    sig = 4'hF; ev_ready = 1'b0; rst = 1'b1;
    model_reset();
    @(negedge clk);

    // Reset values.
    step("reset", 4'hF, 1'b0, 1'b1);
    step("reset", 4'hF, 1'b0, 1'b1);
    check("reset.chan", ev_chan, 0);
    check("reset.kind", ev_kind, 0);

    // Priming: constant high input after reset yields no event.
    repeat (3) step("prime", 4'hF, 1'b0, 1'b0);
    check("prime.no_event", ev_valid, 0);
    repeat (6) step("drain", 4'h0, 1'b1, 1'b0);

    // Order within a channel.
    step("order", 4'b0010, 1'b0, 1'b0);
    step("order", 4'b0000, 1'b0, 1'b0);
    check("order.first_kind", ev_kind, 1);
    repeat (3) step("order", 4'b0000, 1'b1, 1'b0);
    check("order.no_drop", drop_cnt, 0);

    // Drop on channel 2.
    step("drop", 4'b0100, 1'b0, 1'b0);
    step("drop", 4'b0000, 1'b0, 1'b0);
    step("drop", 4'b0100, 1'b0, 1'b0);
    check("drop.pulse", drop_pulse, 1);
    repeat (3) step("drop", 4'b0100, 1'b1, 1'b0);
    check("drop.count", drop_cnt, 1);

    // Round robin.
    repeat (4) step("rr", 4'b1111, 1'b1, 1'b0);
    repeat (4) step("rr", 4'b0100, 1'b1, 1'b0);
    repeat (4) step("rr", 4'b1101, 1'b1, 1'b0);
    repeat (6) step("rr", 4'b0000, 1'b1, 1'b0);

    // Offer lock.
    step("lock", 4'b0100, 1'b0, 1'b0);
    step("lock", 4'b0101, 1'b0, 1'b0);
    step("lock", 4'b0101, 1'b0, 1'b0);
    check("lock.held_chan", ev_chan, 2);
    repeat (3) step("lock", 4'b0101, 1'b1, 1'b0);

    // Saturation, then reset mid-offer.
    s = 4'b0101;
    for (int i = 0; i < 310; i++) begin
      s[0] = ~s[0];
      step("sat", s, 1'b0, 1'b0);
    end
    check("sat.count", drop_cnt, SAT);
    check("sat.offer_up", ev_valid, 1);
    step("rst_mid", s, 1'b0, 1'b1);
    check("rst_mid.valid", ev_valid, 0);
    check("rst_mid.count", drop_cnt, 0);
    step("rst_mid", s, 1'b1, 1'b0);

    // Randomized traffic with changing enables and rare resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        rose_en = N'($urandom);
        fell_en = N'($urandom);
      end
      for (int b = 0; b < N; b++) if ($urandom_range(0, 3) == 0) s[b] = ~s[b];
      step("rand", s, ($urandom_range(0, 2) != 0), ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
